// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// CLKS_PER_BIT clock cycles per serial bit; all outputs are registered.
module uart_tx #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_serial,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int                 CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx_serial;
    logic             r_tx_busy;
    logic             r_tx_done;

    logic             w_bit_end;
    logic [2:0]       w_next_idx;

    assign w_bit_end  = (r_clk_cnt == CNT_MAX);
    assign w_next_idx = r_bit_idx + 3'd1;

    // Outputs are set on the transition into each state, so they lead the state by nothing.
    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge register values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx_serial <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            // Done is low unless the STOP branch raises it, so it can only ever last one cycle.
            r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx_serial <= 1'b1;
                    r_tx_busy   <= 1'b0;
                    if (i_tx_start) begin
                        r_shift     <= i_tx_data;
                        r_clk_cnt   <= '0;
                        r_bit_idx   <= '0;
                        r_tx_serial <= 1'b0;
                        r_tx_busy   <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_clk_cnt   <= '0;
                        r_bit_idx   <= '0;
                        r_tx_serial <= r_shift[0];
                        r_state     <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx_serial <= 1'b1;
                            r_state     <= STOP;
                        end else begin
                            r_bit_idx   <= w_next_idx;
                            r_tx_serial <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt   <= '0;
                        r_tx_serial <= 1'b1;
                        r_tx_busy   <= 1'b0;
                        r_tx_done   <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_tx_serial = r_tx_serial;
    assign o_tx_busy   = r_tx_busy;
    assign o_tx_done   = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with 4 clocks per bit, one with the minimum of 2.
// Expected line values come from a frame model built from the byte and the bit period.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       start4, start2;
    logic [7:0] data4, data2;
    logic       serial4, busy4, done4;
    logic       serial2, busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tx_start (start4),
        .i_tx_data  (data4),
        .o_tx_serial(serial4),
        .o_tx_busy  (busy4),
        .o_tx_done  (done4)
    );

    uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tx_start (start2),
        .i_tx_data  (data2),
        .o_tx_serial(serial2),
        .o_tx_busy  (busy2),
        .o_tx_done  (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just past the edge; stimulus and sampling both happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level in cycle j (1-based) after the accepting edge, for a frame of byte d at c clocks/bit.
    function automatic logic exp_line(input logic [7:0] d, input int j, input int c);
        int pos;
        pos = (j - 1) / c;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[pos-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst    = 1'b1;
        start4 = 1'b1;
        data4  = 8'h00;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({serial4, busy4, done4} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got ser/busy/done=%b exp=100", i, {serial4, busy4, done4});
            end
            if (i < 2) tick();
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_release_start got ser/busy/done=%b exp=010", {serial4, busy4, done4});
        end
        start4 = 1'b0;
        begin
            int  budget;
            logic seen;
            seen = 1'b0;
            for (budget = 0; budget < 100 && !seen; budget++) begin
                tick();
                seen = done4;
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL reset_release_done got no done within 100 cycles exp=done pulse");
            end
        end
        tick();
    endtask

    task automatic test_single_frame();
        data4  = 8'hA5;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            n_tests++;
            if ({serial4, busy4, done4} !== {exp_line(8'hA5, j, 4), 2'b10}) begin
                n_fail++;
                $display("FAIL single_frame cyc=%0d got=%b exp=%b", j, {serial4, busy4, done4}, {exp_line(8'hA5, j, 4), 2'b10});
            end
            tick();
        end
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b101) begin
            n_fail++;
            $display("FAIL single_frame_done got=%b exp=101", {serial4, busy4, done4});
        end
        tick();
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_frame_after got=%b exp=100", {serial4, busy4, done4});
        end
    endtask

    task automatic test_busy_request();
        data4  = 8'hA5;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            n_tests++;
            if ({serial4, busy4, done4} !== {exp_line(8'hA5, j, 4), 2'b10}) begin
                n_fail++;
                $display("FAIL busy_req_frame cyc=%0d got=%b exp=%b", j, {serial4, busy4, done4}, {exp_line(8'hA5, j, 4), 2'b10});
            end
            if (j == 15) begin
                start4 = 1'b1;
                data4  = 8'h3C;
            end else begin
                start4 = 1'b0;
            end
            tick();
        end
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b101) begin
            n_fail++;
            $display("FAIL busy_req_done got=%b exp=101", {serial4, busy4, done4});
        end
        for (int j = 0; j < 12; j++) begin
            tick();
            n_tests++;
            if ({serial4, busy4, done4} !== 3'b100) begin
                n_fail++;
                $display("FAIL busy_req_no_second cyc=%0d got=%b exp=100", j, {serial4, busy4, done4});
            end
        end
    endtask

    task automatic test_back_to_back();
        data4  = 8'h00;
        start4 = 1'b1;
        tick();
        data4 = 8'hFF;
        for (int j = 1; j <= 40; j++) begin
            n_tests++;
            if ({serial4, busy4, done4} !== {exp_line(8'h00, j, 4), 2'b10}) begin
                n_fail++;
                $display("FAIL b2b_first cyc=%0d got=%b exp=%b", j, {serial4, busy4, done4}, {exp_line(8'h00, j, 4), 2'b10});
            end
            tick();
        end
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_gap_done got=%b exp=101", {serial4, busy4, done4});
        end
        tick();
        start4 = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            n_tests++;
            if ({serial4, busy4, done4} !== {exp_line(8'hFF, j, 4), 2'b10}) begin
                n_fail++;
                $display("FAIL b2b_second cyc=%0d got=%b exp=%b", j, {serial4, busy4, done4}, {exp_line(8'hFF, j, 4), 2'b10});
            end
            tick();
        end
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_second_done got=%b exp=101", {serial4, busy4, done4});
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        data4  = 8'hA5;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            n_tests++;
            if ({serial4, busy4, done4} !== {exp_line(8'hA5, j, 4), 2'b10}) begin
                n_fail++;
                $display("FAIL mid_reset_pre cyc=%0d got=%b exp=%b", j, {serial4, busy4, done4}, {exp_line(8'hA5, j, 4), 2'b10});
            end
            if (j < 18) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_reset_next got=%b exp=100", {serial4, busy4, done4});
        end
        for (int j = 0; j < 30; j++) begin
            tick();
            n_tests++;
            if ({serial4, busy4, done4} !== 3'b100) begin
                n_fail++;
                $display("FAIL mid_reset_quiet cyc=%0d got=%b exp=100", j, {serial4, busy4, done4});
            end
        end
        data4  = 8'h5A;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            n_tests++;
            if ({serial4, busy4, done4} !== {exp_line(8'h5A, j, 4), 2'b10}) begin
                n_fail++;
                $display("FAIL mid_reset_after cyc=%0d got=%b exp=%b", j, {serial4, busy4, done4}, {exp_line(8'h5A, j, 4), 2'b10});
            end
            tick();
        end
        n_tests++;
        if ({serial4, busy4, done4} !== 3'b101) begin
            n_fail++;
            $display("FAIL mid_reset_after_done got=%b exp=101", {serial4, busy4, done4});
        end
        tick();
    endtask

    task automatic test_min_divisor();
        n_tests++;
        if ({serial2, busy2, done2} !== 3'b100) begin
            n_fail++;
            $display("FAIL min_div_idle got=%b exp=100", {serial2, busy2, done2});
        end
        data2  = 8'h81;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        data2  = 8'h00;
        for (int j = 1; j <= 20; j++) begin
            n_tests++;
            if ({serial2, busy2, done2} !== {exp_line(8'h81, j, 2), 2'b10}) begin
                n_fail++;
                $display("FAIL min_div_frame cyc=%0d got=%b exp=%b", j, {serial2, busy2, done2}, {exp_line(8'h81, j, 2), 2'b10});
            end
            tick();
        end
        n_tests++;
        if ({serial2, busy2, done2} !== 3'b101) begin
            n_fail++;
            $display("FAIL min_div_done got=%b exp=101", {serial2, busy2, done2});
        end
        tick();
        n_tests++;
        if ({serial2, busy2, done2} !== 3'b100) begin
            n_fail++;
            $display("FAIL min_div_after got=%b exp=100", {serial2, busy2, done2});
        end
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        data4  = 8'h00;
        data2  = 8'h00;
        #1;
        test_reset();
        test_single_frame();
        test_busy_request();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_divisor();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter for the Arty Z7 UART project. It serialises one 8-bit byte per request as an 8N1 frame on the board's TX line. It is the outbound counterpart to the button input path: the one-cycle press pulse produced upstream drives `i_tx_start` directly, and the pulse can be accepted without any conditioning.

## Interface
- `CLKS_PER_BIT`, default 1085 (125 MHz / 115200 baud). Clock cycles per serial bit. Legal range is ≥ 2.
- `i_clk`, in, 1: system clock.
- `i_rst`, in, 1: reset. Synchronous, active-high; clock `i_clk`.
- `i_tx_start`, in, 1: transmit request. Sampled every cycle; a single-cycle pulse is sufficient.
- `i_tx_data`, in, 8: byte to send. Sampled only in the cycle the request is accepted.
- `o_tx_serial`, out, 1: serial line. Idles high.
- `o_tx_busy`, out, 1: high while a frame is in progress.
- `o_tx_done`, out, 1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - `o_tx_serial` = 1, `o_tx_busy` = 0.
  - If `i_tx_start` = 1, latch `i_tx_data` into an internal shift register, clear the bit counter, go to START.
- **START**
  - `o_tx_serial` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA**
  - `o_tx_serial` = shift register bit[index], LSB first.
  - Each bit is held for `CLKS_PER_BIT` cycles.
  - After index 7 completes, go to STOP.
- **STOP**
  - `o_tx_serial` = 1 for `CLKS_PER_BIT` cycles.
  - Then go to IDLE and pulse `o_tx_done` for exactly that first IDLE cycle.
- Counters:
  - Cycle counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - Bit index is 3 bits and is never compared beyond 7.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `i_tx_start` while `o_tx_busy` = 1 is ignored: no queueing, no abort.
- Changes to `i_tx_data` after acceptance have no effect on the frame in progress.
- `i_tx_start` high for multiple cycles starts one frame. If it is still high in the IDLE/done cycle, a second frame starts; no edge detection is performed.
- Reset:
  - Applies in any state, including mid-frame.
  - Next cycle: state IDLE, `o_tx_serial` = 1, `o_tx_busy` = 0, `o_tx_done` = 0, counters 0.
  - A truncated frame is not completed, and `o_tx_done` does not pulse.

## Timing
- Reset values: `o_tx_serial` = 1, `o_tx_busy` = 0, `o_tx_done` = 0.
- Request accepted at clock edge N (`i_tx_start` = 1 in IDLE). From cycle N+1:
  - `o_tx_serial` = 0 and `o_tx_busy` = 1.
- Bit k (k = 0..7) occupies cycles N+1+(k+1)·C .. N+(k+2)·C, where C = `CLKS_PER_BIT`.
- Stop bit occupies cycles N+1+9C .. N+10C.
- Cycle N+10C+1:
  - `o_tx_busy` = 0, `o_tx_done` = 1, `o_tx_serial` = 1.
  - A new `i_tx_start` sampled in this cycle is accepted, so its start bit begins at N+10C+2.
- Back-to-back frame period: 10C+1 cycles.
- `o_tx_busy` is high for exactly 10C cycles per frame.
- `o_tx_done` is high for exactly 1 cycle per completed frame.

## Test plan
- **Reset values.** Hold `i_rst` for 3 cycles with `i_tx_start` = 1 → `o_tx_serial` = 1, `o_tx_busy` = 0, `o_tx_done` = 0 throughout; a frame starts only after `i_rst` is deasserted.
- **Single frame, 0xA5.** Set C = 4; pulse `i_tx_start` one cycle with `i_tx_data` = 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `o_tx_busy` high for 40 cycles; `o_tx_done` pulses once at cycle 41.
- **Request while busy, data change.** Set C = 4; mid-frame, pulse `i_tx_start` and change `i_tx_data` to 0x3C → the current frame is still 0xA5 bits; no second frame follows; exactly one `o_tx_done` pulse.
- **Back-to-back frames.** Hold `i_tx_start` high continuously with 0x00 then 0xFF → the second start bit begins 2 cycles after the first frame's stop bit ends; period is 41 cycles for C = 4.
- **Reset mid-frame.** Assert `i_rst` one cycle during bit 3 → next cycle `o_tx_serial` = 1, `o_tx_busy` = 0, no `o_tx_done`; a subsequent request transmits a full correct frame.
- **Minimum divisor.** Set C = 2 and send 0x81 → each bit is 2 cycles; the frame is correct, with 20 busy cycles.
